// File: rtl/apb_req_arbiter.sv
// Round-robin share of one APB master port among NREQ hold-until-ACK requesters.
// Latency: ACK 3 cycles after the grant edge (zero waits); requesters hold REQ_* until ACK.
module apb_req_arbiter #(
   parameter int NREQ     = 4,
   parameter int SLOT_LSB = 24,
   parameter int TIMEOUT  = 256
) (
   input  logic                PCLK,
   input  logic                PRESETN,
   input  logic [NREQ-1:0]     REQ,
   input  logic [NREQ-1:0]     REQ_WRITE,
   input  logic [NREQ*32-1:0]  REQ_ADDR,
   input  logic [NREQ*32-1:0]  REQ_WDATA,
   output logic [NREQ-1:0]     ACK,
   output logic [31:0]         RDATA,
   output logic                ERR,
   output logic [2:0]          GNT_ID,
   output logic                BUSY,
   output logic [15:0]         PSEL,
   output logic [31:0]         PADDR,
   output logic                PENABLE,
   output logic                PWRITE,
   output logic [31:0]         PWDATA,
   input  logic [31:0]         PRDATA,
   input  logic                PREADY,
   input  logic                PSLVERR
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   state_t           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       gnt_q, gnt_d;
   xfer_t            xfer_q, xfer_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0]       hi_idx, lo_idx, win_idx;
   logic             hi_vld;
   xfer_t            win_xfer;
   logic [CNT_W:0]   cnt_inc;

   // Lowest request at/above the pointer wins; otherwise wrap to the lowest request overall.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      hi_vld = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (REQ[i]) begin
            lo_idx = 3'(i);
            if (3'(i) >= ptr_q) begin
               hi_idx = 3'(i);
               hi_vld = 1'b1;
            end
         end
      end
      win_idx = hi_vld ? hi_idx : lo_idx;
   end

   always_comb begin
      win_xfer = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == 3'(i)) begin
            win_xfer.write = REQ_WRITE[i];
            win_xfer.addr  = REQ_ADDR[32*i +: 32];
            win_xfer.wdata = REQ_WDATA[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      xfer_d  = xfer_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
      case (state_q)
         IDLE: begin
            if (|REQ) begin
               gnt_d   = win_idx;
               ptr_d   = (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
               xfer_d  = win_xfer;
               state_d = SETUP;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (PREADY) begin
               rdata_d = xfer_q.write ? 32'd0 : PRDATA;
               err_d   = PSLVERR;
               state_d = DONE;
            end else begin
               // Saturate rather than wrap so a disabled watchdog never aliases.
               if (!cnt_inc[CNT_W]) begin
                  cnt_d = cnt_inc[CNT_W-1:0];
               end
               if ((TIMEOUT != 0) && (cnt_inc == TO_LIM)) begin
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         xfer_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         xfer_q  <= xfer_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         ACK[i] = (state_q == DONE) && (gnt_q == 3'(i));
      end
      BUSY    = (state_q != IDLE);
      PENABLE = (state_q == ACCESS);
      PSEL    = ((state_q == SETUP) || (state_q == ACCESS)) ?
                (16'd1 << xfer_q.addr[SLOT_LSB +: 4]) : 16'd0;
      PADDR   = xfer_q.addr;
      PWRITE  = xfer_q.write;
      PWDATA  = xfer_q.wdata;
      RDATA   = rdata_q;
      ERR     = err_q;
      GNT_ID  = gnt_q;
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench: main DUT with an 8-cycle watchdog, second DUT with the watchdog disabled.
module tb_apb_req_arbiter;
   localparam int NREQ = 4;

   logic                PCLK = 1'b0;
   logic                PRESETN;
   logic [NREQ-1:0]     REQ, REQ_WRITE, ACK;
   logic [NREQ*32-1:0]  REQ_ADDR, REQ_WDATA;
   logic [31:0]         RDATA, PADDR, PWDATA, PRDATA;
   logic                ERR, BUSY, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [2:0]          GNT_ID;
   logic [15:0]         PSEL;

   logic [NREQ-1:0]     REQ0, REQ_WRITE0, ACK0;
   logic [NREQ*32-1:0]  REQ_ADDR0, REQ_WDATA0;
   logic [31:0]         RDATA0, PADDR0, PWDATA0, PRDATA0;
   logic                ERR0, BUSY0, PENABLE0, PWRITE0, PREADY0, PSLVERR0;
   logic [2:0]          GNT_ID0;
   logic [15:0]         PSEL0;

   int checks = 0;
   int errors = 0;
   int pen_cnt;
   int ack0_seen;
   logic [2:0] order [5];

   apb_req_arbiter #(.NREQ(NREQ), .SLOT_LSB(24), .TIMEOUT(8)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
      .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .RDATA(RDATA),
      .ERR(ERR), .GNT_ID(GNT_ID), .BUSY(BUSY), .PSEL(PSEL), .PADDR(PADDR),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   apb_req_arbiter #(.NREQ(NREQ), .SLOT_LSB(24), .TIMEOUT(0)) dut0 (
      .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ0), .REQ_WRITE(REQ_WRITE0),
      .REQ_ADDR(REQ_ADDR0), .REQ_WDATA(REQ_WDATA0), .ACK(ACK0), .RDATA(RDATA0),
      .ERR(ERR0), .GNT_ID(GNT_ID0), .BUSY(BUSY0), .PSEL(PSEL0), .PADDR(PADDR0),
      .PENABLE(PENABLE0), .PWRITE(PWRITE0), .PWDATA(PWDATA0), .PRDATA(PRDATA0),
      .PREADY(PREADY0), .PSLVERR(PSLVERR0)
   );

   always #5 PCLK = ~PCLK;

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd2; order[3] = 3'd3; order[4] = 3'd0;
      PRESETN = 1'b0;
      REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
      PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
      REQ0 = '0; REQ_WRITE0 = '0; REQ_ADDR0 = '0; REQ_WDATA0 = '0;
      PRDATA0 = '0; PREADY0 = 1'b0; PSLVERR0 = 1'b0;

      // Reset state, with all four requesters already asserted for the contention run.
      REQ = 4'b1111;
      REQ_WRITE = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
         REQ_ADDR[32*i +: 32]  = (32'(i) << 24) | 32'h40;
         REQ_WDATA[32*i +: 32] = 32'h1000 + 32'(i);
      end
      step();
      step();
      chk("rst_ack", 32'(ACK), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_psel", 32'(PSEL), 32'h0);
      chk("rst_penable", 32'(PENABLE), 32'h0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_pwrite", 32'(PWRITE), 32'h0);
      chk("rst_gnt", 32'(GNT_ID), 32'h0);
      chk("rst_rdata", RDATA, 32'h0);
      chk("rst_err", 32'(ERR), 32'h0);
      PRESETN = 1'b1;

      // Contention: grant order 0,1,2,3,0, one IDLE cycle between transfers.
      for (int k = 0; k < 5; k++) begin
         step();
         chk("cont_gnt", 32'(GNT_ID), 32'(order[k]));
         chk("cont_psel", 32'(PSEL), 32'h1 << order[k]);
         step();
         step();
         chk("cont_ack", 32'(ACK), 32'h1 << order[k]);
         step();
         chk("cont_idle_busy", 32'(BUSY), 32'h0);
         chk("cont_idle_ack", 32'(ACK), 32'h0);
      end
      REQ = '0;

      // Single write from requester 1, zero wait states.
      REQ_WRITE = 4'b0010;
      REQ_ADDR[63:32] = 32'h0300_0010;
      REQ_WDATA[63:32] = 32'hA5A5_1234;
      REQ = 4'b0010;
      step();
      chk("wr_psel", 32'(PSEL), 32'h0008);
      chk("wr_penable_setup", 32'(PENABLE), 32'h0);
      chk("wr_paddr", PADDR, 32'h0300_0010);
      chk("wr_pwdata", PWDATA, 32'hA5A5_1234);
      chk("wr_pwrite", 32'(PWRITE), 32'h1);
      chk("wr_gnt", 32'(GNT_ID), 32'h1);
      step();
      chk("wr_penable_access", 32'(PENABLE), 32'h1);
      chk("wr_ack_early", 32'(ACK), 32'h0);
      step();
      chk("wr_ack", 32'(ACK), 32'h2);
      chk("wr_err", 32'(ERR), 32'h0);
      chk("wr_penable_done", 32'(PENABLE), 32'h0);
      chk("wr_psel_done", 32'(PSEL), 32'h0);
      REQ = '0;
      step();
      chk("wr_idle_ack", 32'(ACK), 32'h0);
      chk("wr_idle_busy", 32'(BUSY), 32'h0);
      chk("wr_idle_paddr", PADDR, 32'h0300_0010);

      // Slave error on a write from requester 2.
      REQ_WRITE = 4'b0100;
      REQ_ADDR[95:64] = 32'h0500_0020;
      REQ_WDATA[95:64] = 32'h0BAD_0001;
      PSLVERR = 1'b1;
      REQ = 4'b0100;
      step();
      chk("slv_gnt", 32'(GNT_ID), 32'h2);
      chk("slv_psel", 32'(PSEL), 32'h0020);
      step();
      step();
      chk("slv_ack", 32'(ACK), 32'h4);
      chk("slv_err", 32'(ERR), 32'h1);
      REQ = '0;
      step();
      chk("slv_err_hold", 32'(ERR), 32'h1);

      // Next transfer: PSLVERR during a wait state is ignored, REQ dropped mid-transfer.
      PREADY = 1'b0;
      REQ = 4'b0100;
      step();
      REQ = '0;
      step();
      chk("slv2_penable", 32'(PENABLE), 32'h1);
      PREADY = 1'b1;
      PSLVERR = 1'b0;
      step();
      chk("slv2_ack", 32'(ACK), 32'h4);
      chk("slv2_err", 32'(ERR), 32'h0);
      step();

      // Read from requester 0 with 3 wait states.
      REQ_WRITE = 4'b0000;
      REQ_ADDR[31:0] = 32'h0F00_0004;
      PRDATA = 32'hDEAD_BEEF;
      PREADY = 1'b0;
      REQ = 4'b0001;
      step();
      chk("rd_psel", 32'(PSEL), 32'h8000);
      chk("rd_pwrite", 32'(PWRITE), 32'h0);
      pen_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 3) PREADY = 1'b1;
         if (PENABLE) pen_cnt++;
      end
      step();
      chk("rd_penable_cycles", 32'(pen_cnt), 32'd4);
      chk("rd_ack", 32'(ACK), 32'h1);
      chk("rd_rdata", RDATA, 32'hDEAD_BEEF);
      chk("rd_err", 32'(ERR), 32'h0);
      REQ = '0;
      step();

      // Watchdog timeout on requester 3 after exactly 8 stalled ACCESS cycles.
      REQ_ADDR[127:96] = 32'h0A00_0000;
      PRDATA = 32'h1234_5678;
      PREADY = 1'b0;
      REQ = 4'b1000;
      step();
      step();
      pen_cnt = 0;
      while (PENABLE && pen_cnt < 20) begin
         pen_cnt++;
         step();
      end
      chk("to_access_cycles", 32'(pen_cnt), 32'd8);
      chk("to_ack", 32'(ACK), 32'h8);
      chk("to_err", 32'(ERR), 32'h1);
      chk("to_rdata", RDATA, 32'h0);
      REQ = '0;
      PREADY = 1'b1;
      step();

      // Watchdog disabled: a 1000-cycle stall never completes.
      REQ0 = 4'b0001;
      ack0_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (ACK0 != '0) ack0_seen++;
      end
      chk("nto_ack_count", 32'(ack0_seen), 32'd0);
      chk("nto_penable", 32'(PENABLE0), 32'h1);
      chk("nto_busy", 32'(BUSY0), 32'h1);

      // Reset during a wait state of a requester-1 read; pointer would otherwise be 2.
      REQ_WRITE = 4'b0000;
      PREADY = 1'b0;
      REQ = 4'b0010;
      step();
      step();
      step();
      chk("mid_penable", 32'(PENABLE), 32'h1);
      #2;
      PRESETN = 1'b0;
      #1;
      chk("arst_psel", 32'(PSEL), 32'h0);
      chk("arst_penable", 32'(PENABLE), 32'h0);
      chk("arst_busy", 32'(BUSY), 32'h0);
      chk("arst_ack", 32'(ACK), 32'h0);
      REQ = 4'b0110;
      step();
      step();
      chk("arst_hold_ack", 32'(ACK), 32'h0);
      PRESETN = 1'b1;
      step();
      chk("post_rst_gnt", 32'(GNT_ID), 32'h1);
      chk("post_rst_psel", 32'(PSEL), 32'h0008);
      PREADY = 1'b1;
      step();
      step();
      chk("post_rst_ack", 32'(ACK), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB master port between NREQ local requesters, e.g. a BFM-driven sequencer, a DMA engine and a config loader.
- Each requester uses a simple hold-until-ACK request interface.
- The block runs round-robin arbitration and sequences the APB SETUP/ACCESS phases with wait-state and PSLVERR handling.
- It decodes a 16-slot PSEL vector and aborts stalled slaves with a watchdog timeout.

Parameters:
NREQ, 4, number of requesters (2..8)
SLOT_LSB, 24, PSEL slot index = PADDR[SLOT_LSB+3:SLOT_LSB]
TIMEOUT, 256, consecutive PREADY-low ACCESS cycles before abort (0 = watchdog disabled)

Ports:
PCLK  in  1  clock
PRESETN  in  1  asynchronous active-low reset
REQ  in  NREQ  per-requester transfer request
REQ_WRITE  in  NREQ  per-requester 1=write, 0=read
REQ_ADDR  in  NREQ*32  per-requester address, requester i at bits [32i+31:32i]
REQ_WDATA  in  NREQ*32  per-requester write data, same packing
ACK  out  NREQ  one-cycle completion pulse to the granted requester
RDATA  out  32  read data, valid while ACK is high
ERR  out  1  completion error (PSLVERR or timeout), valid while ACK is high
GNT_ID  out  3  index of the granted requester
BUSY  out  1  high in any state other than IDLE
PSEL  out  16  one-hot slave select
PADDR  out  32  APB address
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PRDATA  in  32  APB read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error

Behaviour:
- Clock and reset: one clock, PCLK. Reset PRESETN is asynchronous and active-low.
- Reset values: all outputs 0, FSM = IDLE, round-robin pointer = 0, watchdog counter = 0. Assertion clears outputs immediately, including mid-transfer; no ACK is issued for an aborted transfer.
- FSM has four states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any REQ bit is high, grant the first requester at or after the pointer, searching upward with wrap-around from NREQ-1 to 0.
  - On grant: pointer <= (grant+1) mod NREQ; register GNT_ID, PADDR, PWRITE, PWDATA from the granted requester's fields; go to SETUP.
  - If no REQ bit is high, stay in IDLE.
- SETUP: PSEL[slot]=1 with all other PSEL bits 0, PENABLE=0. Always go to ACCESS on the next edge.
- ACCESS:
  - PSEL held, PENABLE=1.
  - When PREADY=1: capture RDATA = PRDATA on reads or 0 on writes; capture ERR = PSLVERR; go to DONE.
  - When PREADY=0: increment the watchdog counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, set ERR=1 and RDATA=0 and go to DONE.
- DONE: PSEL=0, PENABLE=0, ACK[GNT_ID]=1 for exactly one cycle; clear the watchdog counter; return to IDLE. No arbitration happens in DONE.
- Minimum transfer: the edge that samples REQ starts SETUP 1 cycle later, ACCESS 2 cycles later, and DONE 3 cycles later with zero wait states. ACK therefore appears 3 cycles after the grant edge. Throughput is 1 transfer per 4 cycles.
- Requester rules:
  - Hold REQ_* stable from REQ rise until ACK.
  - Values are sampled only at grant; later changes are ignored until the next grant.
  - REQ still high in the IDLE cycle after ACK counts as a new request.
- ERR and RDATA hold their value until the next DONE. GNT_ID holds its value until the next grant.
- PADDR, PWRITE and PWDATA hold their last value in IDLE. PSEL and PENABLE are 0 outside SETUP and ACCESS.
- Boundaries:
  - Simultaneous requests are resolved purely by pointer order.
  - A requester dropping REQ mid-transfer does not abort the transfer; ACK is still pulsed.
  - A PSLVERR sampled with PREADY=0 is ignored.
  - The watchdog counter is wide enough for TIMEOUT and saturates.

Test Plan:
- Single write: requester 1 issues write, addr 0x0300_0010, data 0xA5A5_1234, PREADY=1 → PSEL=0x0008, PADDR/PWDATA match, PENABLE high for 1 cycle, ACK[1] 3 cycles after the grant edge, ERR=0.
- Read with 3 wait states: requester 0 reads 0x0F00_0004, PRDATA=0xDEAD_BEEF, PREADY low for 3 ACCESS cycles → PSEL=0x8000, PENABLE high for 4 cycles, RDATA=0xDEAD_BEEF with ACK[0], ERR=0.
- Contention: REQ=4'b1111 held continuously after reset → grant order 0,1,2,3,0; each ACK separated by 4 cycles; BUSY low for 1 cycle between transfers.
- Slave error: PSLVERR=1 with PREADY=1 on a write from requester 2 → ACK[2] with ERR=1. The next transfer with PSLVERR=0 completes with ERR=0.
- Timeout: TIMEOUT=8, PREADY held 0 → DONE after exactly 8 ACCESS cycles, ERR=1, RDATA=0, ACK pulsed. With TIMEOUT=0, a 1000-cycle stall never completes.
- Reset mid-ACCESS: PRESETN low during a wait state → PSEL/PENABLE/BUSY fall without waiting for PCLK, no ACK. After release, REQ=4'b0110 grants requester 1 first (pointer reset to 0).
